// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default starvation
// limit and the starvation counter width helper.
package dmem_arbiter_pkg;

    // Arbiter FSM: IDLE accepts requests, ACK is the single cycle after a host grant.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_ACK  = 1'b1
    } arb_state_e;

    // Consecutive CPU-won cycles tolerated while the host is waiting.
    localparam int unsigned STARVE_MAX_DEFAULT = 4;

    // Counter width able to hold 0..starve_max, never narrower than one bit.
    function automatic int unsigned starve_cnt_width(input int unsigned starve_max);
        return (starve_max == 0) ? 1 : $clog2(starve_max + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_mux2.sv
// Two-input multiplexer used for the address, write-data and write-enable paths
// into the data memory.
module dmem_arbiter_mux2 #(
    parameter int unsigned W = 1
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y
);

    // Select d1 when sel is high, d0 otherwise.
    always_comb begin
        y = sel ? d1 : d0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage (CPU port) and a host/debug port.
// The CPU has priority; a starvation counter forces a host grant after STARVE_MAX
// consecutive CPU wins. A host grant stalls a competing CPU access for that cycle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic          Clk,
    input  logic          Rst,
    // CPU (MEM stage) port
    input  logic          CpuReq,
    input  logic          CpuWE,
    input  logic [AW-1:0] CpuAddr,
    input  logic [DW-1:0] CpuWD,
    output logic [DW-1:0] CpuRD,
    output logic          CpuStall,
    // Host/debug port
    input  logic          HostReq,
    input  logic          HostWE,
    input  logic [AW-1:0] HostAddr,
    input  logic [DW-1:0] HostWD,
    output logic          HostAck,
    output logic [DW-1:0] HostRD,
    // Data memory port
    output logic          DMWE,
    output logic [AW-1:0] DMA,
    output logic [DW-1:0] DMWD,
    input  logic [DW-1:0] DMRD
);

    localparam int unsigned CW = starve_cnt_width(STARVE_MAX);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic [DW-1:0] host_rd_q;
    logic          host_grant;
    logic          cpu_grant;
    logic          starve_at_max;
    logic          cpu_we_gated;

    assign starve_at_max = (starve_cnt_q == STARVE_LIM);
    assign cpu_we_gated  = CpuWE & CpuReq;

    // FSM state register; reset discards any pending ack.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE->ACK on a host grant, ACK always returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (host_grant) state_d = ARB_ACK;
            ARB_ACK:  state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // FSM outputs: grants, CPU stall and the ack pulse (the ACK state itself).
    always_comb begin
        host_grant = HostReq && (state_q == ARB_IDLE) && (!CpuReq || starve_at_max);
        cpu_grant  = CpuReq && !host_grant;
        CpuStall   = CpuReq && host_grant;
        HostAck    = (state_q == ARB_ACK);
    end

    // Starvation counter next value: counts CPU wins while the host waits in IDLE.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (host_grant || !HostReq) begin
            starve_cnt_d = '0;
        end else if ((state_q == ARB_IDLE) && cpu_grant && !starve_at_max) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Host read data capture on every host grant, writes included; held until next grant.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            host_rd_q <= '0;
        end else if (host_grant) begin
            host_rd_q <= DMRD;
        end
    end

    assign HostRD = host_rd_q;
    // Loads see memory data directly; the arbiter adds no latency on the CPU path.
    assign CpuRD  = DMRD;

    dmem_arbiter_mux2 #(.W(AW)) u_mux_addr (
        .sel (host_grant),
        .d0  (CpuAddr),
        .d1  (HostAddr),
        .y   (DMA)
    );

    dmem_arbiter_mux2 #(.W(DW)) u_mux_wd (
        .sel (host_grant),
        .d0  (CpuWD),
        .d1  (HostWD),
        .y   (DMWD)
    );

    dmem_arbiter_mux2 #(.W(1)) u_mux_we (
        .sel (host_grant),
        .d0  (cpu_we_gated),
        .d1  (HostWE),
        .y   (DMWE)
    );

`ifndef SYNTHESIS
    // Stall only ever holds back an actual CPU request.
    a_stall_needs_req: assert property (@(posedge Clk) disable iff (!Rst)
        CpuStall |-> CpuReq);
    // The ACK cycle never grants the host a second time.
    a_no_grant_in_ack: assert property (@(posedge Clk) disable iff (!Rst)
        (state_q == ARB_ACK) |-> !host_grant);
    // Ack is a single-cycle pulse.
    a_ack_pulse: assert property (@(posedge Clk) disable iff (!Rst)
        HostAck |=> !HostAck);
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SM = 4;

    logic          Clk, Rst;
    logic          CpuReq, CpuWE, HostReq, HostWE, z_host_req;
    logic [AW-1:0] CpuAddr, HostAddr;
    logic [DW-1:0] CpuWD, HostWD;

    logic [DW-1:0] cpu_rd, host_rd, dm_wd, dm_rd;
    logic [AW-1:0] dm_a;
    logic          cpu_stall, host_ack, dm_we;

    logic [DW-1:0] z_cpu_rd, z_host_rd, z_dm_wd, z_dm_rd;
    logic [AW-1:0] z_dm_a;
    logic          z_cpu_stall, z_host_ack, z_dm_we;

    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_z [16];

    int vectors;
    int miscompares;

    dmem_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(SM)) dut (
        .Clk(Clk), .Rst(Rst),
        .CpuReq(CpuReq), .CpuWE(CpuWE), .CpuAddr(CpuAddr), .CpuWD(CpuWD),
        .CpuRD(cpu_rd), .CpuStall(cpu_stall),
        .HostReq(HostReq), .HostWE(HostWE), .HostAddr(HostAddr), .HostWD(HostWD),
        .HostAck(host_ack), .HostRD(host_rd),
        .DMWE(dm_we), .DMA(dm_a), .DMWD(dm_wd), .DMRD(dm_rd)
    );

    dmem_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(0)) dut_z (
        .Clk(Clk), .Rst(Rst),
        .CpuReq(CpuReq), .CpuWE(CpuWE), .CpuAddr(CpuAddr), .CpuWD(CpuWD),
        .CpuRD(z_cpu_rd), .CpuStall(z_cpu_stall),
        .HostReq(z_host_req), .HostWE(HostWE), .HostAddr(HostAddr), .HostWD(HostWD),
        .HostAck(z_host_ack), .HostRD(z_host_rd),
        .DMWE(z_dm_we), .DMA(z_dm_a), .DMWD(z_dm_wd), .DMRD(z_dm_rd)
    );

    // Single-ported memories: combinational read, write on the rising edge.
    assign dm_rd   = mem_a[dm_a[3:0]];
    assign z_dm_rd = mem_z[z_dm_a[3:0]];
    always @(posedge Clk) if (dm_we) mem_a[dm_a[3:0]] <= dm_wd;
    always @(posedge Clk) if (z_dm_we) mem_z[z_dm_a[3:0]] <= z_dm_wd;
    initial for (int i = 0; i < 16; i++) begin
        mem_a[i] <= '0;
        mem_z[i] <= '0;
    end

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // ---------------- reference model (main instance) ----------------
    // in_ack: host was served last cycle; waited: CPU wins since the host started waiting.
    bit            m_in_ack;
    int            m_waited;
    logic [DW-1:0] m_hostrd;
    logic [DW-1:0] ref_mem [16];

    function automatic bit exp_grant();
        return HostReq && !m_in_ack && (!CpuReq || m_waited >= SM);
    endfunction

    task automatic model_reset();
        m_in_ack = 1'b0;
        m_waited = 0;
        m_hostrd = '0;
    endtask

    task automatic model_step();
        bit hg;
        hg = exp_grant();
        if (hg) m_hostrd = ref_mem[HostAddr[3:0]];
        if (hg && HostWE) ref_mem[HostAddr[3:0]] = HostWD;
        else if (!hg && CpuReq && CpuWE) ref_mem[CpuAddr[3:0]] = CpuWD;
        if (!HostReq || hg) m_waited = 0;
        else if (!m_in_ack && CpuReq && m_waited < SM) m_waited++;
        m_in_ack = hg;
    endtask

    task automatic idle_inputs();
        CpuReq = 0; CpuWE = 0; CpuAddr = '0; CpuWD = '0;
        HostReq = 0; HostWE = 0; HostAddr = '0; HostWD = '0; z_host_req = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Rst = 1'b0;
        idle_inputs();
        #1;
        vectors++; if (host_ack !== 1'b0) begin miscompares++; $display("FAIL reset.ack got=%0h exp=0", host_ack); end
        vectors++; if (host_rd !== '0) begin miscompares++; $display("FAIL reset.host_rd got=%0h exp=0", host_rd); end
        vectors++; if (dm_we !== 1'b0) begin miscompares++; $display("FAIL reset.dm_we got=%0h exp=0", dm_we); end
        CpuReq = 1; CpuAddr = 8; HostReq = 1; HostAddr = 3;
        #1;
        vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL reset.stall got=%0h exp=0", cpu_stall); end
        vectors++; if (dm_a !== 32'd8) begin miscompares++; $display("FAIL reset.cpu_first got=%0h exp=8", dm_a); end
        idle_inputs();
        @(negedge Clk);
        Rst = 1'b1;
        model_reset();
        model_step();
    endtask

    task automatic test_cpu_only();
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            idle_inputs();
            CpuReq = 1; CpuWE = 1; CpuAddr = 8; CpuWD = 32'hDEAD;
            #1;
            vectors++; if (dm_we !== 1'b1) begin miscompares++; $display("FAIL cpu_only.we got=%0h exp=1", dm_we); end
            vectors++; if (dm_a !== 32'd8) begin miscompares++; $display("FAIL cpu_only.addr got=%0h exp=8", dm_a); end
            vectors++; if (dm_wd !== 32'hDEAD) begin miscompares++; $display("FAIL cpu_only.wd got=%0h exp=dead", dm_wd); end
            vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL cpu_only.stall got=%0h exp=0", cpu_stall); end
            model_step();
        end
        @(negedge Clk);
        CpuWE = 0;
        #1;
        vectors++; if (cpu_rd !== 32'hDEAD) begin miscompares++; $display("FAIL cpu_only.load got=%0h exp=dead", cpu_rd); end
        vectors++; if (dm_we !== 1'b0) begin miscompares++; $display("FAIL cpu_only.load_we got=%0h exp=0", dm_we); end
        model_step();
    endtask

    task automatic test_host_only();
        // Write 0x1234 to address 3 through the host port.
        @(negedge Clk);
        idle_inputs();
        CpuAddr = 8; HostReq = 1; HostWE = 1; HostAddr = 3; HostWD = 32'h1234;
        #1;
        vectors++; if (dm_a !== 32'd3) begin miscompares++; $display("FAIL host_wr.addr got=%0h exp=3", dm_a); end
        vectors++; if (dm_we !== 1'b1) begin miscompares++; $display("FAIL host_wr.we got=%0h exp=1", dm_we); end
        vectors++; if (dm_wd !== 32'h1234) begin miscompares++; $display("FAIL host_wr.wd got=%0h exp=1234", dm_wd); end
        vectors++; if (host_ack !== 1'b0) begin miscompares++; $display("FAIL host_wr.ack0 got=%0h exp=0", host_ack); end
        model_step();
        @(negedge Clk);
        HostReq = 0;
        #1;
        vectors++; if (host_ack !== 1'b1) begin miscompares++; $display("FAIL host_wr.ack1 got=%0h exp=1", host_ack); end
        model_step();
        // Read it back: grant in cycle 0, ack and data in cycle 1.
        @(negedge Clk);
        HostReq = 1; HostWE = 0; HostAddr = 3;
        #1;
        vectors++; if (dm_a !== 32'd3) begin miscompares++; $display("FAIL host_rd.addr got=%0h exp=3", dm_a); end
        vectors++; if (dm_we !== 1'b0) begin miscompares++; $display("FAIL host_rd.we got=%0h exp=0", dm_we); end
        model_step();
        @(negedge Clk);
        HostReq = 0;
        #1;
        vectors++; if (host_ack !== 1'b1) begin miscompares++; $display("FAIL host_rd.ack got=%0h exp=1", host_ack); end
        vectors++; if (host_rd !== 32'h1234) begin miscompares++; $display("FAIL host_rd.data got=%0h exp=1234", host_rd); end
        model_step();
        @(negedge Clk);
        #1;
        vectors++; if (host_ack !== 1'b0) begin miscompares++; $display("FAIL host_rd.ack_drop got=%0h exp=0", host_ack); end
        vectors++; if (host_rd !== 32'h1234) begin miscompares++; $display("FAIL host_rd.held got=%0h exp=1234", host_rd); end
        model_step();
    endtask

    task automatic test_reset_mid_ack();
        @(negedge Clk);
        idle_inputs();
        CpuAddr = 8; HostReq = 1; HostAddr = 3;
        #1;
        model_step();
        @(negedge Clk);
        #1;
        vectors++; if (host_ack !== 1'b1 || host_rd !== 32'h1234) begin
            miscompares++; $display("FAIL mid_ack.pre got=%0h/%0h exp=1/1234", host_ack, host_rd);
        end
        Rst = 1'b0;
        #1;
        vectors++; if (host_ack !== 1'b0) begin miscompares++; $display("FAIL mid_ack.ack got=%0h exp=0", host_ack); end
        vectors++; if (host_rd !== '0) begin miscompares++; $display("FAIL mid_ack.host_rd got=%0h exp=0", host_rd); end
        // Back in IDLE, so the still-high request is granted again.
        vectors++; if (dm_a !== 32'd3) begin miscompares++; $display("FAIL mid_ack.idle got=%0h exp=3", dm_a); end
        HostReq = 0;
        @(negedge Clk);
        Rst = 1'b1;
        model_reset();
        model_step();
    endtask

    task automatic test_starvation();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i <= SM; i++) begin
                @(negedge Clk);
                idle_inputs();
                CpuReq = 1; CpuAddr = 8;
                HostReq = 1; HostWE = 1; HostAddr = 4; HostWD = 32'h55 + 32'(r * 17);
                #1;
                if (i < SM) begin
                    vectors++; if (cpu_stall !== 1'b0 || dm_a !== 32'd8) begin
                        miscompares++;
                        $display("FAIL starve.cpu_win r%0d c%0d got=%0h/%0h exp=0/8", r, i, cpu_stall, dm_a);
                    end
                end else begin
                    vectors++; if (cpu_stall !== 1'b1 || dm_a !== 32'd4 || dm_we !== 1'b1) begin
                        miscompares++;
                        $display("FAIL starve.host_win r%0d got=%0h/%0h/%0h exp=1/4/1", r, cpu_stall, dm_a, dm_we);
                    end
                end
                model_step();
            end
            @(negedge Clk);
            HostReq = 0;
            #1;
            vectors++; if (host_ack !== 1'b1 || cpu_stall !== 1'b0) begin
                miscompares++; $display("FAIL starve.ack r%0d got=%0h/%0h exp=1/0", r, host_ack, cpu_stall);
            end
            model_step();
        end
    endtask

    task automatic test_held_request();
        int acks;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            idle_inputs();
            CpuAddr = 8; HostAddr = 4; HostReq = (i < 3);
            #1;
            if (host_ack === 1'b1) acks++;
            if (i == 0 || i == 2) begin
                vectors++; if (dm_a !== 32'd4 || host_ack !== 1'b0) begin
                    miscompares++; $display("FAIL held.grant c%0d got=%0h/%0h exp=4/0", i, dm_a, host_ack);
                end
            end else begin
                vectors++; if (dm_a !== 32'd8 || host_ack !== 1'b1) begin
                    miscompares++; $display("FAIL held.ack c%0d got=%0h/%0h exp=8/1", i, dm_a, host_ack);
                end
                vectors++; if (host_rd !== 32'h66) begin
                    miscompares++; $display("FAIL held.data c%0d got=%0h exp=66", i, host_rd);
                end
            end
            model_step();
        end
        vectors++; if (acks != 2) begin miscompares++; $display("FAIL held.pulses got=%0d exp=2", acks); end
    endtask

    task automatic test_starve_zero();
        // c0 host write granted despite CpuReq; c1 ack; c2 host read granted; c3 ack with data.
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            idle_inputs();
            CpuReq = 1; CpuAddr = 8; HostAddr = 4; HostWD = 32'h77;
            HostWE = (i == 0); z_host_req = (i == 0 || i == 2);
            #1;
            if (i == 0 || i == 2) begin
                vectors++; if (z_cpu_stall !== 1'b1 || z_dm_a !== 32'd4 || z_host_ack !== 1'b0) begin
                    miscompares++;
                    $display("FAIL zero.grant c%0d got=%0h/%0h/%0h exp=1/4/0", i, z_cpu_stall, z_dm_a, z_host_ack);
                end
                vectors++; if (z_dm_we !== HostWE) begin
                    miscompares++; $display("FAIL zero.we c%0d got=%0h exp=%0h", i, z_dm_we, HostWE);
                end
            end else begin
                vectors++; if (z_cpu_stall !== 1'b0 || z_dm_a !== 32'd8 || z_host_ack !== 1'b1) begin
                    miscompares++;
                    $display("FAIL zero.ack c%0d got=%0h/%0h/%0h exp=0/8/1", i, z_cpu_stall, z_dm_a, z_host_ack);
                end
            end
            if (i == 3) begin
                vectors++; if (z_host_rd !== 32'h77) begin
                    miscompares++; $display("FAIL zero.data got=%0h exp=77", z_host_rd);
                end
                vectors++; if (z_cpu_rd !== 32'hDEAD) begin
                    miscompares++; $display("FAIL zero.cpu_rd got=%0h exp=dead", z_cpu_rd);
                end
            end
            vectors++; if (cpu_stall !== 1'b0) begin
                miscompares++; $display("FAIL zero.main_stall c%0d got=%0h exp=0", i, cpu_stall);
            end
            model_step();
        end
    endtask

    task automatic test_random();
        bit            hg;
        logic [AW-1:0] ea;
        @(negedge Clk);
        idle_inputs();
        #1;
        model_step();
        for (int n = 0; n < 2000; n++) begin
            @(negedge Clk);
            CpuReq  = ($urandom_range(0, 3) != 0);
            CpuWE   = $urandom_range(0, 1) != 0;
            CpuAddr = AW'($urandom_range(0, 15));
            CpuWD   = $urandom;
            if (!HostReq) begin
                if ($urandom_range(0, 2) == 0) begin
                    HostReq  = 1;
                    HostWE   = $urandom_range(0, 1) != 0;
                    HostAddr = AW'($urandom_range(0, 15));
                    HostWD   = $urandom;
                end
            end else if (m_in_ack && $urandom_range(0, 3) != 0) begin
                HostReq = 0;
            end
            #1;
            hg = exp_grant();
            ea = hg ? HostAddr : CpuAddr;
            vectors++; if (cpu_stall !== (CpuReq && hg)) begin
                miscompares++; $display("FAIL rand.stall n%0d got=%0h exp=%0h", n, cpu_stall, CpuReq && hg);
            end
            vectors++; if (dm_a !== ea) begin
                miscompares++; $display("FAIL rand.addr n%0d got=%0h exp=%0h", n, dm_a, ea);
            end
            vectors++; if (dm_we !== (hg ? HostWE : (CpuReq && CpuWE))) begin
                miscompares++; $display("FAIL rand.we n%0d got=%0h", n, dm_we);
            end
            vectors++; if (dm_wd !== (hg ? HostWD : CpuWD)) begin
                miscompares++; $display("FAIL rand.wd n%0d got=%0h", n, dm_wd);
            end
            vectors++; if (host_ack !== m_in_ack) begin
                miscompares++; $display("FAIL rand.ack n%0d got=%0h exp=%0h", n, host_ack, m_in_ack);
            end
            vectors++; if (host_rd !== m_hostrd) begin
                miscompares++; $display("FAIL rand.host_rd n%0d got=%0h exp=%0h", n, host_rd, m_hostrd);
            end
            vectors++; if (cpu_rd !== ref_mem[ea[3:0]]) begin
                miscompares++; $display("FAIL rand.cpu_rd n%0d got=%0h exp=%0h", n, cpu_rd, ref_mem[ea[3:0]]);
            end
            model_step();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        model_reset();
        test_reset();
        test_cpu_only();
        test_host_only();
        test_reset_mid_ack();
        test_starvation();
        test_held_request();
        test_starve_zero();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
